// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and 4:1 data mux for four requesters sharing one write port.
// Optional completed-beat counter enabled by defining MUX_ARB_BEATCNT_EN.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned PTR_RESET = 3
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic [3:0]  Req,
  input  logic [3:0]  Last,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic [15:0] C,
  input  logic [15:0] D,
  input  logic        Out_ready,
  output logic [3:0]  Gnt,
  output logic [1:0]  S,
  output logic [15:0] Out_data,
  output logic        Out_valid,
  output logic [15:0] Beat_count
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  localparam int unsigned   CntW      = 5;
  localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);
  localparam logic [1:0]    PtrInit   = 2'(PTR_RESET);

  state_e            st_q, st_d;
  logic [1:0]        cur_q, cur_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              beat;
  logic              rel_burst;

  // First requester after ptr in circular order; ptr itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] req);
    logic [1:0] idx;
    logic [1:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  always_comb begin
    st_d      = st_q;
    cur_d     = cur_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rel_burst = 1'b0;
    beat      = (st_q == StGrant) && Out_ready;

    unique case (st_q)
      StIdle: begin
        if (|Req) begin
          st_d  = StGrant;
          cur_d = rr_pick(ptr_q, Req);
          cnt_d = '0;
        end
      end
      StGrant: begin
        if (beat) begin
          cnt_d = cnt_q + 1'b1;
          // A request dropped on the beat cycle acts as the final beat.
          if (Last[cur_q] || !Req[cur_q] || (cnt_q == BurstLast)) begin
            rel_burst = 1'b1;
          end
        end else if (!Req[cur_q]) begin
          rel_burst = 1'b1;
        end

        if (rel_burst) begin
          ptr_d = cur_q;
          cnt_d = '0;
          if (|Req) begin
            cur_d = rr_pick(cur_q, Req);
          end else begin
            st_d = StIdle;
          end
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      st_q  <= StIdle;
      cur_q <= 2'b00;
      ptr_q <= PtrInit;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cur_q <= cur_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // cur_q is held while idle, so S (and the mux) stay put between grants.
  always_comb begin
    S         = cur_q;
    Out_valid = (st_q == StGrant);
    Gnt       = (st_q == StGrant) ? (4'b0001 << cur_q) : 4'b0000;
  end

  always_comb begin
    Out_data = A;
    unique case (S)
      2'd0:    Out_data = A;
      2'd1:    Out_data = B;
      2'd2:    Out_data = C;
      2'd3:    Out_data = D;
      default: Out_data = A;
    endcase
  end

`ifdef MUX_ARB_BEATCNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (beat && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      beat_cnt_q <= 16'h0000;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign Beat_count = beat_cnt_q;
`else
  assign Beat_count = 16'h0000;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (Reset_n) begin
      assert ($onehot0(Gnt));
      assert (cnt_q < CntW'(MAX_BURST));
    end
  end
`endif

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 16-bit 4:1 bus mux (Mux_4x2).
- Four requesters share one downstream write port, e.g. a register-file write-back or memory data bus.
- The block grants one requester at a time and drives the mux select S.
- It presents the selected data with a valid/ready handshake, and supports bounded bursts per grant.

Parameters:
MAX_BURST, 4, maximum beats per grant before forced re-arbitration; legal range 1..16.
PTR_RESET, 3, last-served pointer value after reset, so requester 0 has first priority by default.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
Reset_n  input  1  synchronous active-low reset, sampled on the rising edge of CLK.
Req  input  4  per-requester request; bit i belongs to requester i.
Last  input  4  per-requester final-beat flag; only meaningful while that requester is granted.
A, B, C, D  input  16 each  requester 0..3 data, routed to the internal Mux_4x2.
Out_ready  input  1  downstream accepts the beat this cycle.
Gnt  output  4  one-hot grant; all zeros when idle.
S  output  2  mux select / index of the granted requester.
Out_data  output  16  mux output, combinational from S and A..D.
Out_valid  output  1  a beat is presented on Out_data.
Beat_count  output  16  completed-beat counter (see Optional Feature).

Behaviour:
- Reset: Reset_n low at a rising edge sets the following.
  - state=IDLE, Gnt=4'b0000, S=2'b00, Out_valid=0.
  - burst counter=0, last pointer=PTR_RESET, Beat_count=0.
  - Reset mid-burst aborts the burst at once, with no completion beat.
- States:
  - IDLE: Gnt=0, Out_valid=0. S holds its last value so the mux does not toggle needlessly.
  - GRANT: Gnt=onehot(cur), S=cur, Out_valid=1.
- Winner selection: first i with Req[i]=1, searching (ptr+1), (ptr+2), (ptr+3), (ptr+4), all mod 4. The current pointer value is the one used.
- IDLE -> GRANT: any Req bit high at a rising edge moves the block to GRANT with cur=winner. Latency from Req to Gnt is 1 cycle.
- Beat: Out_valid & Out_ready at a rising edge. The burst counter increments on each beat.
- End of burst: a beat ends the burst when Last[cur]=1 or the burst counter = MAX_BURST-1. On end of burst:
  - ptr<=cur and counter<=0.
  - Winner is recomputed with ptr=cur, excluding nothing; cur may win again only if it is the sole requester.
  - Any Req high -> stay in GRANT with the new winner, giving back-to-back grants with no idle bubble.
  - Otherwise -> IDLE.
- Abort: in GRANT, Req[cur]=0 with no beat at an edge triggers an abort.
  - The block releases without a beat: ptr<=cur, counter<=0, then re-arbitrates exactly as at end of burst.
- Simultaneous events:
  - A beat in the same cycle Req[cur] drops counts as a beat; end-of-burst rules then apply, and the drop is treated as Last.
  - Req changes on non-granted lines never disturb an active burst.
- Stall: Out_ready=0 holds S, Gnt and Out_valid stable indefinitely; no timeout.
- Gnt is always one-hot or zero. S changes only at rising edges.

Optional Feature:
- MUX_ARB_BEATCNT_EN defined:
  - Beat_count is a 16-bit counter incremented on every beat.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined:
  - Beat_count is tied to 16'h0000 and the counter logic is absent.
  - All other behaviour is identical.

Test Plan:
- Reset then Req=4'b1111, Last=4'b1111, Out_ready=1 -> Gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles after the 1-cycle initial latency; S=0,1,2,3,0; Out_data follows A,B,C,D.
- Burst limit: MAX_BURST=4, Req=4'b0011, Last=0, Out_ready=1 -> 4 beats with S=0, then 4 beats with S=1, alternating; no idle cycle between grants.
- Stall: granted req 2, C=16'hBEEF, Out_ready=0 for 5 cycles -> S=2, Out_valid=1 and Out_data=16'hBEEF stable; one beat counted when Out_ready=1.
- Abort: req 1 granted, drops Req with Out_ready=0 -> next cycle Gnt=0 (or next winner when Req=4'b1001 gives Gnt=1000); no beat counted.
- Reset mid-burst: Reset_n low for 1 cycle during beat 2 of a burst -> next cycle Gnt=0, Out_valid=0, S=0, next grant goes to requester 0 if requesting.
- With MUX_ARB_BEATCNT_EN: 10 beats -> Beat_count=16'd10; preload by running to saturation -> holds 16'hFFFF. Without the macro, Beat_count=0 throughout.
